// File: rtl/pipe_mips32_core_if.sv
// Load, debug and status signals of pipe_mips32_core bundled as one port.
interface pipe_mips32_core_if;
    logic        halted;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic [9:0]  dbg_mem_addr;
    logic [31:0] dbg_mem_data;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] dbg_reg_data;

    modport master (
        input  halted, dbg_mem_data, dbg_reg_data,
        output ld_en, ld_addr, ld_data, dbg_mem_addr, dbg_reg_addr
    );

    modport slave (
        output halted, dbg_mem_data, dbg_reg_data,
        input  ld_en, ld_addr, ld_data, dbg_mem_addr, dbg_reg_addr
    );
endinterface

// File: rtl/pipe_mips32_core.sv
// Five-stage in-order MIPS32-subset core (IF, ID, EX, MEM, WB) with a 32x32
// register file, one unified word-addressed memory, full forwarding,
// a one-cycle load-use stall and branches resolved in EX.
module pipe_mips32_core #(
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    pipe_mips32_core_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_ADD   = 6'b000000, OP_SUB   = 6'b000001,
                           OP_AND   = 6'b000010, OP_OR    = 6'b000011,
                           OP_SLT   = 6'b000100, OP_MUL   = 6'b000101,
                           OP_LW    = 6'b001000, OP_SW    = 6'b001001,
                           OP_ADDI  = 6'b001010, OP_SUBI  = 6'b001011,
                           OP_SLTI  = 6'b001100, OP_BNEQZ = 6'b001101,
                           OP_BEQZ  = 6'b001110, OP_HLT   = 6'b111111;

    typedef struct packed {
        logic [5:0] op;
        logic       wr;
        logic [4:0] dst;
        logic       use_rs;
        logic       use_rt;
        logic       imm_op;
        logic       is_lw;
        logic       is_sw;
        logic       is_br;
        logic       is_hlt;
    } dec_t;

    typedef struct packed { logic valid; logic [31:0] ir; logic [31:0] npc; } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic        wr;
        logic [4:0]  dst;
        logic        imm_op;
        logic        is_lw;
        logic        is_sw;
        logic        is_br;
        logic        is_hlt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic        is_lw;
        logic        is_sw;
        logic        is_hlt;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] sd;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic        is_hlt;
        logic [4:0]  dst;
        logic [31:0] val;
    } mem_wb_t;

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d    = '0;
        d.op = ir[31:26];
        case (ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                d.wr = 1'b1; d.dst = ir[15:11]; d.use_rs = 1'b1; d.use_rt = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_SLTI: begin
                d.wr = 1'b1; d.dst = ir[20:16]; d.use_rs = 1'b1; d.imm_op = 1'b1;
            end
            OP_LW: begin
                d.wr = 1'b1; d.dst = ir[20:16]; d.use_rs = 1'b1; d.imm_op = 1'b1;
                d.is_lw = 1'b1;
            end
            OP_SW: begin
                d.use_rs = 1'b1; d.use_rt = 1'b1; d.imm_op = 1'b1; d.is_sw = 1'b1;
            end
            OP_BNEQZ, OP_BEQZ: begin
                d.use_rs = 1'b1; d.is_br = 1'b1;
            end
            OP_HLT:  d.is_hlt = 1'b1;
            default: d.op = 6'b111110;  // unknown opcode: no effect anywhere
        endcase
        return d;
    endfunction

    logic [31:0] mem  [MEM_WORDS];
    logic [31:0] regs [32];
    logic [31:0] pc;
    logic        halted;
    if_id_t      if_id;
    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;

    // EX/MEM result first, then MEM/WB; R0 and in-flight load addresses never forward.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] id_val,
                                        input ex_mem_t em, input mem_wb_t mw);
        if (em.valid && em.wr && !em.is_lw && em.dst != 5'd0 && em.dst == src)
            return em.alu;
        else if (mw.valid && mw.wr && mw.dst != 5'd0 && mw.dst == src)
            return mw.val;
        return id_val;
    endfunction

    logic        wb_we, stall, hlt_in_id, br_taken;
    dec_t        dec;
    logic [31:0] id_a, id_b, ex_a, ex_b, op2, alu_out, br_target, mem_rdata;

    assign wb_we = mem_wb.valid && mem_wb.wr && (mem_wb.dst != 5'd0) && !halted;

    // ID: decode, write-through register reads, load-use and HLT detection.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        dec       = decode(if_id.ir);
        id_a      = (wb_we && mem_wb.dst == if_id.ir[25:21]) ? mem_wb.val : regs[if_id.ir[25:21]];
        id_b      = (wb_we && mem_wb.dst == if_id.ir[20:16]) ? mem_wb.val : regs[if_id.ir[20:16]];
        stall     = if_id.valid && id_ex.valid && id_ex.is_lw && id_ex.dst != 5'd0 &&
                    ((dec.use_rs && if_id.ir[25:21] == id_ex.dst) ||
                     (dec.use_rt && if_id.ir[20:16] == id_ex.dst));
        hlt_in_id = if_id.valid && dec.is_hlt;
    end

    // EX: forwarded operands, ALU and branch resolution.
    always_comb begin
        ex_a    = fwd(id_ex.rs, id_ex.a, ex_mem, mem_wb);
        ex_b    = fwd(id_ex.rt, id_ex.b, ex_mem, mem_wb);
        op2     = id_ex.imm_op ? id_ex.imm : ex_b;
        alu_out = '0;
        case (id_ex.op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: alu_out = ex_a + op2;
            OP_SUB, OP_SUBI:               alu_out = ex_a - op2;
            OP_AND:                        alu_out = ex_a & op2;
            OP_OR:                         alu_out = ex_a | op2;
            OP_SLT, OP_SLTI:               alu_out = {31'd0, $signed(ex_a) < $signed(op2)};
            OP_MUL:                        alu_out = ex_a * op2;
            default:                       alu_out = '0;
        endcase
        br_taken  = id_ex.valid && id_ex.is_br &&
                    ((id_ex.op == OP_BEQZ) ? (ex_a == '0) : (ex_a != '0));
        br_target = id_ex.npc + id_ex.imm;
    end

    assign mem_rdata = mem[ex_mem.alu[AW-1:0]];

    // Pipeline registers, PC and halt flag; everything freezes once halted.
    // NOTE: sequential state uses non-blocking assignments so every stage sees the
    // previous cycle's values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            mem_wb.valid  <= ex_mem.valid;
            mem_wb.wr     <= ex_mem.wr;
            mem_wb.is_hlt <= ex_mem.is_hlt;
            mem_wb.dst    <= ex_mem.dst;
            mem_wb.val    <= ex_mem.is_lw ? mem_rdata : ex_mem.alu;

            ex_mem.valid  <= id_ex.valid;
            ex_mem.wr     <= id_ex.wr;
            ex_mem.is_lw  <= id_ex.is_lw;
            ex_mem.is_sw  <= id_ex.is_sw;
            ex_mem.is_hlt <= id_ex.is_hlt;
            ex_mem.dst    <= id_ex.dst;
            ex_mem.alu    <= alu_out;
            ex_mem.sd     <= ex_b;

            if (br_taken) begin
                pc    <= br_target;
                if_id <= '0;
                id_ex <= '0;
            end else if (stall) begin
                id_ex <= '0;
            end else begin
                id_ex.valid  <= if_id.valid;
                id_ex.op     <= dec.op;
                id_ex.wr     <= dec.wr;
                id_ex.dst    <= dec.dst;
                id_ex.imm_op <= dec.imm_op;
                id_ex.is_lw  <= dec.is_lw;
                id_ex.is_sw  <= dec.is_sw;
                id_ex.is_br  <= dec.is_br;
                id_ex.is_hlt <= dec.is_hlt;
                id_ex.rs     <= if_id.ir[25:21];
                id_ex.rt     <= if_id.ir[20:16];
                id_ex.a      <= id_a;
                id_ex.b      <= id_b;
                id_ex.imm    <= {{16{if_id.ir[15]}}, if_id.ir[15:0]};
                id_ex.npc    <= if_id.npc;
                if (hlt_in_id) begin
                    if_id <= '0;
                end else begin
                    if_id.valid <= 1'b1;
                    if_id.ir    <= mem[pc[AW-1:0]];
                    if_id.npc   <= pc + 32'd1;
                    pc          <= pc + 32'd1;
                end
            end

            if (mem_wb.valid && mem_wb.is_hlt) halted <= 1'b1;
        end
    end

    // Register file: cleared on reset, written from WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[mem_wb.dst] <= mem_wb.val;
        end
    end

    // Unified memory: external load port has priority over SW from MEM.
    // NOTE: the memory array has no reset so programs survive rst and it maps to RAM.
    always_ff @(posedge clk) begin
        if (bus.ld_en)
            mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
        else if (!rst && !halted && ex_mem.valid && ex_mem.is_sw)
            mem[ex_mem.alu[AW-1:0]] <= ex_mem.sd;
    end

    assign bus.halted       = halted;
    assign bus.dbg_mem_data = mem[bus.dbg_mem_addr[AW-1:0]];
    assign bus.dbg_reg_data = regs[bus.dbg_reg_addr];
endmodule

// File: tb/tb_pipe_mips32_core.sv
// Directed self-checking bench for pipe_mips32_core.
module tb_pipe_mips32_core;
    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc;
    logic [31:0] acc;
    logic [31:0] prog [$];
    logic [31:0] fact [$];

    pipe_mips32_core_if bus ();

    pipe_mips32_core #(.MEM_WORDS(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
        bus.dbg_reg_addr = 5'(r);
        #1;
        check(tag, bus.dbg_reg_data, exp);
    endtask

    task automatic chk_mem(input string tag, input int a, input logic [31:0] exp);
        bus.dbg_mem_addr = 10'(a);
        #1;
        check(tag, bus.dbg_mem_data, exp);
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 10'(addr);
        bus.ld_data = data;
        @(posedge clk);
        #1;
        bus.ld_en = 1'b0;
    endtask

    task automatic load_prog();
        foreach (prog[i]) load(i, prog[i]);
    endtask

    task automatic enter_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Releases reset and counts rising edges until halted, bounded.
    task automatic run_to_halt(output int cycles);
        rst    = 1'b0;
        cycles = 0;
        while (bus.halted !== 1'b1 && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("halt_reached", {31'd0, bus.halted}, 32'd1);
    endtask

    initial begin
        bus.ld_en        = 1'b0;
        bus.ld_addr      = '0;
        bus.ld_data      = '0;
        bus.dbg_mem_addr = '0;
        bus.dbg_reg_addr = '0;
        rst              = 1'b1;
        fact = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
                 32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
                 32'h3460fffc, 32'h2542fffe, 32'hfc000000};
        repeat (2) @(posedge clk);
        #1;
        check("reset_halted_low", {31'd0, bus.halted}, 32'd0);

        // HLT only: halted rises exactly at the 5th edge after release
        load(0, 32'hfc000000);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("hlt_edge4_low", {31'd0, bus.halted}, 32'd0);
        @(posedge clk);
        #1;
        check("hlt_edge5_high", {31'd0, bus.halted}, 32'd1);
        acc = '0;
        for (int r = 0; r < 32; r++) begin
            bus.dbg_reg_addr = 5'(r);
            #1;
            acc = acc | bus.dbg_reg_data;
        end
        check("hlt_regs_zero", acc, 32'd0);

        // ALU and forwarding, back-to-back; no stalls so HLT (index 6) halts at edge 11
        enter_reset();
        check("rst_clears_halted", {31'd0, bus.halted}, 32'd0);
        prog = '{32'h2801000a,   // ADDI R1,R0,10
                 32'h28020014,   // ADDI R2,R0,20
                 32'h00221800,   // ADD  R3,R1,R2
                 32'h04612000,   // SUB  R4,R3,R1
                 32'h14832800,   // MUL  R5,R4,R3
                 32'h3026ffff,   // SLTI R6,R1,-1
                 32'hfc000000};  // HLT
        load_prog();
        run_to_halt(cyc);
        check("alu_cycles", cyc, 32'd11);
        chk_reg("alu_r3", 3, 32'd30);
        chk_reg("alu_r4", 4, 32'd20);
        chk_reg("alu_r5", 5, 32'd600);
        chk_reg("alu_r6", 6, 32'd0);

        // Load-use: one stall pushes HLT (index 4) from edge 9 to edge 10
        enter_reset();
        load(100, 32'd7);
        prog = '{32'h28010064,   // ADDI R1,R0,100
                 32'h20220000,   // LW   R2,0(R1)
                 32'h00421800,   // ADD  R3,R2,R2
                 32'h24230001,   // SW   R3,1(R1)
                 32'hfc000000};  // HLT
        load_prog();
        run_to_halt(cyc);
        check("lu_cycles", cyc, 32'd10);
        chk_reg("lu_r2", 2, 32'd7);
        chk_reg("lu_r3", 3, 32'd14);
        chk_mem("lu_mem101", 101, 32'd14);

        // Factorial of 8
        enter_reset();
        load(200, 32'd8);
        load(198, 32'd0);
        prog = fact;
        load_prog();
        run_to_halt(cyc);
        chk_reg("fact_r2", 2, 32'd40320);
        chk_reg("fact_r3", 3, 32'd0);
        chk_mem("fact_mem198", 198, 32'd40320);
        chk_mem("fact_mem200", 200, 32'd8);
        repeat (5) @(posedge clk);
        #1;
        check("fact_halt_sticky", {31'd0, bus.halted}, 32'd1);
        chk_reg("fact_frozen_r2", 2, 32'd40320);
        load(300, 32'h1234abcd);
        chk_mem("ld_while_halted", 300, 32'h1234abcd);

        // Taken BEQZ squashes two instructions; penalty 2 keeps HLT at edge 11
        for (int v = 0; v < 2; v++) begin
            enter_reset();
            prog = '{(v == 0) ? 32'h38000002 : 32'h34000002,  // BEQZ / BNEQZ R0,+2
                     32'h28010001,   // ADDI R1,R0,1
                     32'h28020002,   // ADDI R2,R0,2
                     32'h28030003,   // ADDI R3,R0,3
                     32'h28000005,   // ADDI R0,R0,5 (discarded)
                     32'h00032000,   // ADD  R4,R0,R3
                     32'hfc000000};  // HLT
            load_prog();
            run_to_halt(cyc);
            check((v == 0) ? "beqz_cycles" : "bneqz_cycles", cyc, 32'd11);
            chk_reg((v == 0) ? "beqz_r1" : "bneqz_r1", 1, (v == 0) ? 32'd0 : 32'd1);
            chk_reg((v == 0) ? "beqz_r2" : "bneqz_r2", 2, (v == 0) ? 32'd0 : 32'd2);
            chk_reg((v == 0) ? "beqz_r3" : "bneqz_r3", 3, 32'd3);
            chk_reg((v == 0) ? "beqz_r4" : "bneqz_r4", 4, 32'd3);
            chk_reg((v == 0) ? "beqz_r0" : "bneqz_r0", 0, 32'd0);
        end

        // Mid-run reset during the factorial loop, then a clean rerun
        enter_reset();
        load(200, 32'd8);
        load(198, 32'd0);
        prog = fact;
        load_prog();
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("mid_running", {31'd0, bus.halted}, 32'd0);
        chk_reg("mid_r10_before", 10, 32'd200);
        enter_reset();
        check("mid_rst_halted", {31'd0, bus.halted}, 32'd0);
        chk_reg("mid_rst_r10", 10, 32'd0);
        chk_reg("mid_rst_r2", 2, 32'd0);
        run_to_halt(cyc);
        chk_reg("mid_rerun_r2", 2, 32'd40320);
        chk_reg("mid_rerun_r3", 3, 32'd0);
        chk_mem("mid_rerun_mem198", 198, 32'd40320);
        chk_mem("mid_rerun_mem200", 200, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
